tm_qm_ctrl: RTL

Sequencer for the second-level traffic-manager queue data store (head/tail/depth/linked-list/packet-descriptor BRAMs, 1-cycle read latency). It accepts enqueue and dequeue requests and arbitrates between them round-robin. It serializes each request into BRAM read/modify/write steps so no read-after-write hazard exists. After reset it clears every queue's depth. It sits between the scheduler front end and the data store, inside the TM queue manager.

---
 rtl/meta_package.sv | 19 +
 rtl/tm_qm_ctrl_pkg.sv | 17 +
 rtl/tm_qm_ctrl_rr2.sv | 25 ++
 rtl/tm_qm_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/meta_package.sv
// Types shared across the traffic-manager metadata path: the scheduler packet
// descriptor and the queue-manager operation tag used by monitors.
`ifndef SECOND_LVL_QUEUE_ID_NBITS
`define SECOND_LVL_QUEUE_ID_NBITS 3
`endif

package meta_package;

    typedef struct packed {
        logic [11:0] pkt_len;
        logic [3:0]  cls;
    } sch_pkt_desc_type;

    typedef enum logic {
        ENQ = 1'b0,
        DEQ = 1'b1
    } tm_qm_op_e;

endpackage

// File: rtl/tm_qm_ctrl_pkg.sv
// Local constants and helpers for the queue-manager sequencer.
package tm_qm_ctrl_pkg;

    localparam int RR_ENQ = 0;
    localparam int RR_DEQ = 1;

    // With both requesters pending, grant the one that was not served last.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_deq);
        logic [1:0] g;
        g = req;
        if (req == 2'b11) begin
            g = last_deq ? 2'b01 : 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/tm_qm_ctrl_rr2.sv
// Two-requester round-robin picker; bit 0 is enqueue, bit 1 is dequeue.
module tm_qm_ctrl_rr2
    import tm_qm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_deq;

    assign grant = rr_pick(req, last_deq);

    // Starting from "dequeue served last" lets enqueue win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_deq <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_deq <= grant[RR_DEQ];
        end
    end

endmodule

// File: rtl/tm_qm_ctrl.sv
// Second-level TM queue sequencer: arbitrates enqueue/dequeue and turns each
// request into read/modify/write steps on the head/tail/depth/ll/descriptor RAMs.
`ifndef SECOND_LVL_QUEUE_ID_NBITS
`define SECOND_LVL_QUEUE_ID_NBITS 3
`endif

module tm_qm_ctrl
    import meta_package::*;
    import tm_qm_ctrl_pkg::*;
#(
    parameter int QUEUE_ID_NBITS      = `SECOND_LVL_QUEUE_ID_NBITS,
    parameter int QUEUE_ENTRIES_NBITS = `SECOND_LVL_QUEUE_ID_NBITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enq_req,
    input  logic [QUEUE_ID_NBITS-1:0]      enq_qid,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] enq_entry,
    input  sch_pkt_desc_type               enq_desc,
    output logic                           enq_ack,
    output logic                           enq_drop,
    input  logic                           deq_req,
    input  logic [QUEUE_ID_NBITS-1:0]      deq_qid,
    output logic                           deq_ack,
    output logic                           deq_empty,
    output logic [QUEUE_ENTRIES_NBITS-1:0] deq_entry,
    output sch_pkt_desc_type               deq_desc,
    output logic                           init_done,
    output logic                           head_wr,
    output logic [QUEUE_ID_NBITS-1:0]      head_raddr,
    output logic [QUEUE_ID_NBITS-1:0]      head_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] head_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] head_rdata,
    output logic                           tail_wr,
    output logic [QUEUE_ID_NBITS-1:0]      tail_raddr,
    output logic [QUEUE_ID_NBITS-1:0]      tail_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] tail_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] tail_rdata,
    output logic                           depth_wr,
    output logic [QUEUE_ID_NBITS-1:0]      depth_raddr,
    output logic [QUEUE_ID_NBITS-1:0]      depth_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] depth_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] depth_rdata,
    output logic                           ll_wr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] ll_raddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] ll_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] ll_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] ll_rdata,
    output logic                           pkt_desc_wr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_raddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_waddr,
    output sch_pkt_desc_type               pkt_desc_wdata,
    input  sch_pkt_desc_type               pkt_desc_rdata
);

    typedef enum logic [2:0] {INIT, IDLE, ENQ_RD, ENQ_WR, DEQ_RD, DEQ_LL, DEQ_WR} state_e;

    localparam logic [QUEUE_ENTRIES_NBITS-1:0] DEPTH_MAX = '1;
    localparam logic [QUEUE_ENTRIES_NBITS-1:0] DEPTH_ONE = QUEUE_ENTRIES_NBITS'(1);

    state_e                           state;
    logic [QUEUE_ID_NBITS-1:0]        init_cnt;
    logic [QUEUE_ID_NBITS-1:0]        qid;
    logic [QUEUE_ENTRIES_NBITS-1:0]   entry;
    logic [QUEUE_ENTRIES_NBITS-1:0]   h;
    logic [QUEUE_ENTRIES_NBITS-1:0]   d;
    sch_pkt_desc_type                 desc;
    logic [1:0]                       req;
    logic [1:0]                       grant;

    // A request whose ack is showing this cycle is the one just finished, not a new one.
    assign req = (state == IDLE) ? {deq_req & ~deq_ack, enq_req & ~enq_ack} : 2'b00;

    tm_qm_ctrl_rr2 u_rr2 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (state == IDLE),
        .grant   (grant)
    );

    // The ll/descriptor reads are addressed by head_rdata of this same cycle, so
    // they skip the output register to keep a dequeue at three cycles.
    assign ll_raddr       = (state == DEQ_LL) ? head_rdata : '0;
    assign pkt_desc_raddr = (state == DEQ_LL) ? head_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= INIT;
            init_cnt       <= '0;
            init_done      <= 1'b0;
            qid            <= '0;
            entry          <= '0;
            desc           <= '0;
            h              <= '0;
            d              <= '0;
            enq_ack        <= 1'b0;
            enq_drop       <= 1'b0;
            deq_ack        <= 1'b0;
            deq_empty      <= 1'b0;
            deq_entry      <= '0;
            deq_desc       <= '0;
            head_wr        <= 1'b0;
            head_raddr     <= '0;
            head_waddr     <= '0;
            head_wdata     <= '0;
            tail_wr        <= 1'b0;
            tail_raddr     <= '0;
            tail_waddr     <= '0;
            tail_wdata     <= '0;
            depth_wr       <= 1'b0;
            depth_raddr    <= '0;
            depth_waddr    <= '0;
            depth_wdata    <= '0;
            ll_wr          <= 1'b0;
            ll_waddr       <= '0;
            ll_wdata       <= '0;
            pkt_desc_wr    <= 1'b0;
            pkt_desc_waddr <= '0;
            pkt_desc_wdata <= '0;
        end else begin
            enq_ack     <= 1'b0;
            enq_drop    <= 1'b0;
            deq_ack     <= 1'b0;
            deq_empty   <= 1'b0;
            head_wr     <= 1'b0;
            tail_wr     <= 1'b0;
            depth_wr    <= 1'b0;
            ll_wr       <= 1'b0;
            pkt_desc_wr <= 1'b0;
            case (state)
                INIT: begin
                    depth_wr    <= 1'b1;
                    depth_waddr <= init_cnt;
                    depth_wdata <= '0;
                    init_cnt    <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    if (grant[RR_ENQ]) begin
                        qid         <= enq_qid;
                        entry       <= enq_entry;
                        desc        <= enq_desc;
                        tail_raddr  <= enq_qid;
                        depth_raddr <= enq_qid;
                        state       <= ENQ_RD;
                    end else if (grant[RR_DEQ]) begin
                        qid         <= deq_qid;
                        head_raddr  <= deq_qid;
                        depth_raddr <= deq_qid;
                        state       <= DEQ_RD;
                    end
                end
                ENQ_RD: state <= ENQ_WR;
                ENQ_WR: begin
                    enq_ack <= 1'b1;
                    state   <= IDLE;
                    if (depth_rdata == DEPTH_MAX) begin
                        enq_drop <= 1'b1;
                    end else begin
                        pkt_desc_wr    <= 1'b1;
                        pkt_desc_waddr <= entry;
                        pkt_desc_wdata <= desc;
                        if (depth_rdata == '0) begin
                            head_wr    <= 1'b1;
                            head_waddr <= qid;
                            head_wdata <= entry;
                        end else begin
                            ll_wr    <= 1'b1;
                            ll_waddr <= tail_rdata;
                            ll_wdata <= entry;
                        end
                        tail_wr     <= 1'b1;
                        tail_waddr  <= qid;
                        tail_wdata  <= entry;
                        depth_wr    <= 1'b1;
                        depth_waddr <= qid;
                        depth_wdata <= depth_rdata + 1'b1;
                    end
                end
                DEQ_RD: state <= DEQ_LL;
                DEQ_LL: begin
                    if (depth_rdata == '0) begin
                        deq_ack   <= 1'b1;
                        deq_empty <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        h     <= head_rdata;
                        d     <= depth_rdata;
                        state <= DEQ_WR;
                    end
                end
                DEQ_WR: begin
                    depth_wr    <= 1'b1;
                    depth_waddr <= qid;
                    depth_wdata <= d - 1'b1;
                    if (d != DEPTH_ONE) begin
                        head_wr    <= 1'b1;
                        head_waddr <= qid;
                        head_wdata <= ll_rdata;
                    end
                    deq_entry <= h;
                    deq_desc  <= pkt_desc_rdata;
                    deq_ack   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
